sfx_scheduler: RTL
==================

# sfx_scheduler

Sound-effect scheduler between the game logic (ball collision, scoring and game-start pulses) and the tone generator (`music_top`). It latches one-cycle event pulses and arbitrates them by fixed priority. It plays one effect at a time for a parameterised duration, with a silent gap between effects. It drives the generator's enable/direction inputs plus an effect ID, replacing ad-hoc per-collision enable latches with a single sequenced resource.

## Interface
Parameters:
- `SHORT_CYC`, 8_000_000, play length in clk cycles for wall/paddle effects (≥1).
- `LONG_CYC`, 30_000_000, play length for point/start effects (≥1).
- `GAP_CYC`, 1_000_000, forced-silence length after every effect (≥1).
- `CNT_W`, 25, down-counter width; must hold max(SHORT_CYC, LONG_CYC, GAP_CYC)−1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-low reset; sampled on posedge `clk`.
- `ev_wall`  in  1  one-cycle pulse: ball hit top/bottom wall.
- `ev_paddle`  in  1  one-cycle pulse: ball hit a paddle.
- `ev_point`  in  2  one-cycle pulses: [0] player 1 scored, [1] player 2 scored.
- `ev_start`  in  1  one-cycle pulse: serve/game start.
- `mute`  in  1  level: silence and discard all effects while high.
- `sfx_en`  out  1  registered; generator enable.
- `sfx_dir`  out  1  registered; generator direction, 1 for point effects, else 0.
- `sfx_id`  out  3  registered; 0 none, 1 wall, 2 paddle, 3 point P1, 4 point P2, 5 start.
- `busy`  out  1  registered; high in PLAY or GAP.

## Operation
- Pending register `pend[4:0]` holds one bit per ID 1..5. An input pulse sets its bit; a repeat while already set merges (no queueing of duplicates).
- Priority, highest first: start(5) > point P1(3) > point P2(4) > paddle(2) > wall(1).
- Class: IDs 1, 2 are SHORT (`SHORT_CYC`). IDs 3, 4, 5 are LONG (`LONG_CYC`).
- FSM states: IDLE, PLAY, GAP.
  - IDLE: if `mute`=0 and `pend`≠0, the next state is PLAY. Grant the highest-priority ID, clear its pend bit, load `cnt` = duration−1.
  - PLAY: `cnt` decrements each cycle. At `cnt`=0, go to GAP and load `cnt` = GAP_CYC−1.
  - PLAY preemption: only a SHORT effect can be preempted, and only by a pending LONG ID. The LONG ID is granted immediately, its pend bit is cleared, and `cnt` is reloaded. The state stays PLAY with no gap. The preempted effect is dropped, not re-pended. A LONG effect is never preempted.
  - GAP: `cnt` decrements. At `cnt`=0, go to IDLE.
- Outputs are registered from next-state:
  - `sfx_en`=1 iff the state is PLAY.
  - `sfx_id` is the granted ID in PLAY, else 0.
  - `sfx_dir`=1 iff `sfx_id`∈{3,4}.
- Mute:
  - While `mute`=1, `pend` is held at 0 and incoming pulses are ignored.
  - PLAY or GAP aborts to IDLE on the next edge, with `cnt` zeroed.
- If a pulse sets a bit on the same edge that the bit is granted and cleared, the set wins: the bit stays pending and replays later.
- Simultaneous pulses all latch; they are served in priority order, each separated by a gap.

## Timing
- Reset (`rst`=0 at posedge): state IDLE, `pend`=0, `cnt`=0. `sfx_en`=0, `sfx_dir`=0, `sfx_id`=0, `busy`=0. Reset mid-PLAY silences on the same edge and discards all pending bits.
- Latency: a pulse sampled at edge t sets `pend` at t. From IDLE, `sfx_en`/`sfx_id` are valid after edge t+1.
- `sfx_en` stays high for exactly the duration of the granted class in cycles, unless preempted or muted.
- After an effect ends, `sfx_en` is low for exactly GAP_CYC+1 cycles (GAP plus one IDLE cycle) before the next pending effect.
- On preemption, the new `sfx_id` appears one edge after the LONG pend bit is observed. `sfx_en` stays continuously high.
- `busy` goes high on the same edge as `sfx_en` rises and falls on the edge the FSM enters IDLE.

## Test plan
Parameters for all scenarios: SHORT_CYC=4, LONG_CYC=10, GAP_CYC=3.
- Reset: hold `rst`=0 for 3 cycles with `ev_wall`=1 → all outputs 0 and `pend`=0. After release, no effect plays.
- Single paddle pulse at cycle 10 → `sfx_id`=2, `sfx_en`=1 for cycles 11–14. `busy` drops at the IDLE entry edge (cycle 18). `sfx_dir`=0 throughout.
- Same-cycle pulses `ev_wall`, `ev_paddle`, `ev_point`=2'b10 → order id 4 (10 cycles, `sfx_dir`=1), then 2 (4 cycles), then 1 (4 cycles). Each gap is 4 low cycles.
- Preemption: wall pulse, then `ev_start` 2 cycles into wall playback → `sfx_id` switches 1→5 with `sfx_en` continuously high. Id 5 plays 10 cycles, and the wall effect is not replayed.
- Mute mid-LONG (id 3) plus pulses during mute → silenced next edge, FSM in IDLE, nothing plays after `mute` drops.
- Re-pend race: `ev_paddle` pulse on the exact edge id 2 is granted from pend → id 2 plays twice, separated by a 4-cycle gap.

Source files
------------

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: latches sound-effect event pulses and plays them one at a time by fixed priority,
// with a forced silent gap after each effect.
module sfx_scheduler #(
   parameter int SHORT_CYC = 8_000_000,
   parameter int LONG_CYC  = 30_000_000,
   parameter int GAP_CYC   = 1_000_000,
   parameter int CNT_W     = 25
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       ev_wall,
   input  logic       ev_paddle,
   input  logic [1:0] ev_point,
   input  logic       ev_start,
   input  logic       mute,
   output logic       sfx_en,
   output logic       sfx_dir,
   output logic [2:0] sfx_id,
   output logic       busy
);
   localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2;
   localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
   logic [1:0] state, ns;
   logic [4:0] pend, pend_n, clr, set;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0] id_n, best, best_long;
   logic grant;
   // pend bit i holds effect ID i+1
   assign set = {ev_start, ev_point, ev_paddle, ev_wall};
   assign best_long = pend[4] ? 3'd5 : pend[2] ? 3'd3 : pend[3] ? 3'd4 : 3'd0;
   assign best = best_long != 3'd0 ? best_long : pend[1] ? 3'd2 : pend[0] ? 3'd1 : 3'd0;
   always_comb begin
      ns = state;
      cnt_n = cnt;
      id_n = sfx_id;
      grant = 1'b0;
      case (state)
         IDLE:
            if (pend != 5'd0) begin
               ns = PLAY;
               id_n = best;
               grant = 1'b1;
               cnt_n = best >= 3'd3 ? LONG_LD : SHORT_LD;
            end
         PLAY:
            if (sfx_id < 3'd3 && best_long != 3'd0) begin
               id_n = best_long;
               grant = 1'b1;
               cnt_n = LONG_LD;
            end else if (cnt == '0) begin
               ns = GAP;
               id_n = 3'd0;
               cnt_n = GAP_LD;
            end else
               cnt_n = cnt - 1'b1;
         GAP:
            if (cnt == '0)
               ns = IDLE;
            else
               cnt_n = cnt - 1'b1;
         default: begin
            ns = IDLE;
            id_n = 3'd0;
            cnt_n = '0;
         end
      endcase
      if (mute) begin
         ns = IDLE;
         id_n = 3'd0;
         cnt_n = '0;
         grant = 1'b0;
      end
   end
   // a pulse arriving on the grant edge re-sets the bit it clears
   assign clr = grant ? 5'd1 << (id_n - 3'd1) : 5'd0;
   assign pend_n = mute ? 5'd0 : (pend & ~clr) | set;
   always_ff @(posedge clk)
      if (!rst) begin
         state <= IDLE;
         pend <= 5'd0;
         cnt <= '0;
         sfx_en <= 1'b0;
         sfx_dir <= 1'b0;
         sfx_id <= 3'd0;
         busy <= 1'b0;
      end else begin
         state <= ns;
         pend <= pend_n;
         cnt <= cnt_n;
         sfx_en <= ns == PLAY;
         sfx_id <= id_n;
         sfx_dir <= id_n == 3'd3 || id_n == 3'd4;
         busy <= ns != IDLE;
      end
endmodule
